// File: rtl/spi_mstr_gen_if.sv
// Bus bundle for spi_mstr_gen: host-side request/response plus SPI pins.
// SPI_LSB_FIRST_EN adds the lsb_first request bit.
interface spi_mstr_gen_if #(
    parameter int DATA_W = 16
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic              wrt;
    logic [DATA_W-1:0] data_out;
    logic [LEN_W-1:0]  len;
    logic              cpol;
    logic              cpha;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic              MISO;
    logic              SS_n;
    logic              SCLK;
    logic              MOSI;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data_in;

`ifdef SPI_LSB_FIRST_EN
    modport master (input wrt, data_out, len, cpol, cpha, lsb_first, MISO,
                    output SS_n, SCLK, MOSI, busy, done, data_in);
    modport slave  (output wrt, data_out, len, cpol, cpha, lsb_first, MISO,
                    input SS_n, SCLK, MOSI, busy, done, data_in);
`else
    modport master (input wrt, data_out, len, cpol, cpha, MISO,
                    output SS_n, SCLK, MOSI, busy, done, data_in);
    modport slave  (output wrt, data_out, len, cpol, cpha, MISO,
                    input SS_n, SCLK, MOSI, busy, done, data_in);
`endif
endinterface

// File: rtl/spi_mstr_gen.sv
// Parametrised SPI master: runtime length 1..DATA_W, all CPOL/CPHA modes, SCLK divider, full-duplex.
// Define SPI_LSB_FIRST_EN to add the lsb_first request bit (LSB-first shifting).
module spi_mstr_gen #(
    parameter int DATA_W   = 16,
    parameter int HALF_DIV = 2
) (
    input logic            clk,
    input logic            rst_n,
    spi_mstr_gen_if.master bus
);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int EC_W  = LEN_W + 1;
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EC_W-1:0]   ecnt_q, ecnt_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, din_q, din_d;
    logic              ss_n_q, ss_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              lsb_in;
`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = bus.lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    logic              tick, accept, edge_fire, last_edge, sample_edge;
    logic [LEN_W-1:0]  eff_len;
    logic [DATA_W-1:0] tx_load, rx_msb, rx_lsb;

    assign tick      = (div_q == DIV_W'(HALF_DIV - 1));
    // A wrt landing in the done cycle is dropped, so the host sees busy=0 before re-arming.
    assign accept    = (state_q == IDLE) && bus.wrt && !done_q;
    assign edge_fire = tick && (((state_q == SETUP) && !ss_n_q) || (state_q == SHIFT));
    assign last_edge = (ecnt_q == (({1'b0, n_q} << 1) - EC_W'(1)));
    // Edge number is ecnt_q+1; odd edges sample when cpha=0, even edges when cpha=1.
    assign sample_edge = ~ecnt_q[0] ^ cpha_q;

    assign eff_len = ((bus.len == '0) || (bus.len > LEN_W'(DATA_W))) ? LEN_W'(DATA_W) : bus.len;
    // MSB-first left-aligns the word so the outgoing bit is always the top bit.
    assign tx_load = lsb_in ? bus.data_out : (bus.data_out << (LEN_W'(DATA_W) - eff_len));
    assign rx_msb  = {rx_q[DATA_W-2:0], bus.MISO};
    assign rx_lsb  = (rx_q >> 1) | ({DATA_W{bus.MISO}} & (DATA_W'(1) << (n_q - LEN_W'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            ecnt_q  <= '0;
            n_q     <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            din_q   <= '0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ecnt_q  <= ecnt_d;
            n_q     <= n_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            din_q   <= din_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (edge_fire) state_d = SHIFT;
            SHIFT:   if (edge_fire && last_edge) state_d = HOLD;
            HOLD:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d  = (state_q == IDLE) ? '0 : (tick ? '0 : div_q + DIV_W'(1));
        ecnt_d = ecnt_q;
        n_d    = n_q;
        cpol_d = cpol_q;
        cpha_d = cpha_q;
        lsb_d  = lsb_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        din_d  = din_q;
        ss_n_d = ss_n_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        busy_d = busy_q;
        done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    n_d    = eff_len;
                    cpol_d = bus.cpol;
                    cpha_d = bus.cpha;
                    lsb_d  = lsb_in;
                    sclk_d = bus.cpol;
                    busy_d = 1'b1;
                    ecnt_d = '0;
                    rx_d   = '0;
                    tx_d   = tx_load;
                    // cpha=0 needs the first bit on the wire before the leading edge.
                    if (!bus.cpha) begin
                        mosi_d = lsb_in ? tx_load[0] : tx_load[DATA_W-1];
                        tx_d   = lsb_in ? (tx_load >> 1) : (tx_load << 1);
                    end
                end
            end
            SETUP: begin
                if (ss_n_q) begin
                    ss_n_d = 1'b0;
                    div_d  = '0;
                end
            end
            HOLD: begin
                if (tick) begin
                    ss_n_d = 1'b1;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    din_d  = rx_q;
                end
            end
            default: ;
        endcase

        if (edge_fire) begin
            sclk_d = ~sclk_q;
            ecnt_d = ecnt_q + EC_W'(1);
            if (sample_edge) begin
                rx_d = lsb_q ? rx_lsb : rx_msb;
            end else begin
                mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
                tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
            end
        end
    end

    assign bus.SS_n    = ss_n_q;
    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.data_in = din_q;
endmodule

// File: tb/tb_spi_mstr_gen.sv
// Self-checking bench for spi_mstr_gen: timing model from edge arithmetic plus directed literal checks.
module tb_spi_mstr_gen;
    localparam int DW = 16;
    localparam int HD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_mstr_gen_if #(.DATA_W(DW)) bus ();
    spi_mstr_gen #(.DATA_W(DW), .HALF_DIV(HD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic          loop       = 1'b1;
    logic [DW-1:0] slave_word = '0;
    int            cur_n      = DW;
    logic          miso_r     = 1'b0;
    assign bus.MISO = loop ? bus.MOSI : miso_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    function automatic int eff_n(input logic [4:0] l);
        return ((l == 5'd0) || (int'(l) > DW)) ? DW : int'(l);
    endfunction

    function automatic logic [DW-1:0] mask_n(input int n);
        logic [DW-1:0] m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Reference: cycle t after the accepting edge; edge k lands at t=1+k*HD, done at t=1+(2N+1)*HD.
    logic          run_m = 1'b0;
    int            t_m = 0, done_t = 0, n_m = DW;
    logic          cpol_m = 1'b0, cpha_m = 1'b0, lsb_m = 1'b0;
    logic [DW-1:0] dout_m = '0, rx_m = '0, din_m = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_m  <= 1'b0;
            t_m    <= 0;
            din_m  <= '0;
            cpol_m <= 1'b0;
            cpha_m <= 1'b0;
            lsb_m  <= 1'b0;
        end else if (run_m) begin
            if (t_m == done_t) run_m <= 1'b0;
            else begin
                t_m <= t_m + 1;
                if (t_m + 1 == done_t) din_m <= rx_m;
            end
        end else if (bus.wrt) begin
            run_m  <= 1'b1;
            t_m    <= 0;
            n_m    <= eff_n(bus.len);
            done_t <= 1 + (2 * eff_n(bus.len) + 1) * HD;
            cpol_m <= bus.cpol;
            cpha_m <= bus.cpha;
            dout_m <= bus.data_out;
            rx_m   <= (loop ? bus.data_out : slave_word) & mask_n(eff_n(bus.len));
`ifdef SPI_LSB_FIRST_EN
            lsb_m  <= bus.lsb_first;
`endif
        end
    end

    int            cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            rises = 0, falls = 0, done_cnt = 0, ss_falls = 0, lat = 0, acc_cyc = 0, sc = 0;
    logic [DW-1:0] mon_bits = '0;
    logic          first_mosi = 1'b0;
    logic          prev_sclk = 1'b0, prev_ss = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin : cmp
        int   k, j;
        logic e_ss, e_sclk, e_busy, e_done, e_mosi;
        if (rst_n) begin
            if (run_m) begin
                k = (t_m >= 1) ? (t_m - 1) / HD : 0;
                if (k > 2 * n_m) k = 2 * n_m;
                e_ss   = !((t_m >= 1) && (t_m < done_t));
                e_sclk = cpol_m ^ k[0];
                e_busy = (t_m < done_t);
                e_done = (t_m == done_t);
            end else begin
                e_ss   = 1'b1;
                e_sclk = cpol_m;
                e_busy = 1'b0;
                e_done = 1'b0;
            end
            chk1("SS_n", bus.SS_n, e_ss);
            chk1("SCLK", bus.SCLK, e_sclk);
            chk1("busy", bus.busy, e_busy);
            chk1("done", bus.done, e_done);
            chk("data_in", 32'(bus.data_in), 32'(din_m));
            if (run_m && (t_m >= 1) && ((t_m - 1) % HD == 0)) begin
                k = (t_m - 1) / HD;
                if ((k >= 1) && (k <= 2 * n_m) && (((k % 2) == 1) == (cpha_m == 1'b0))) begin
                    j      = (k - 1) / 2;
                    e_mosi = lsb_m ? dout_m[j] : dout_m[n_m - 1 - j];
                    chk1("MOSI", bus.MOSI, e_mosi);
                    mon_bits <= {mon_bits[DW-2:0], bus.MOSI};
                    if (j == 0) first_mosi <= bus.MOSI;
                end
            end
        end
        if (bus.busy && !prev_busy) begin
            rises    <= 0;
            falls    <= 0;
            acc_cyc  <= cyc;
            mon_bits <= '0;
        end else if (!bus.SS_n && (bus.SCLK !== prev_sclk)) begin
            if (bus.SCLK) rises <= rises + 1;
            else          falls <= falls + 1;
        end
        if (bus.done && !prev_done) begin
            done_cnt <= done_cnt + 1;
            lat      <= cyc - acc_cyc;
        end
        if (!bus.SS_n && prev_ss) ss_falls <= ss_falls + 1;
        // Slave for cpha=1: presents the next bit on each odd (launch) edge.
        if (bus.SS_n) begin
            sc     <= 0;
            miso_r <= 1'b0;
        end else if (bus.SCLK !== prev_sclk) begin
            sc <= sc + 1;
            if (sc % 2 == 0) miso_r <= slave_word[cur_n - 1 - sc / 2];
        end
        prev_sclk <= bus.SCLK;
        prev_ss   <= bus.SS_n;
        prev_busy <= bus.busy;
        prev_done <= bus.done;
    end

    task automatic start(input logic [DW-1:0] d, input logic [4:0] l, input logic pol,
                         input logic pha, input logic lsb);
        @(posedge clk); #1;
        bus.data_out = d;
        bus.len      = l;
        bus.cpol     = pol;
        bus.cpha     = pha;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = lsb;
`else
        if (lsb) cur_n = eff_n(l);
`endif
        cur_n   = eff_n(l);
        bus.wrt = 1'b1;
        @(posedge clk); #1;
        bus.wrt      = 1'b0;
        // Scramble request inputs mid-transfer; the latched copy must win.
        bus.data_out = ~d;
        bus.len      = 5'd3;
        bus.cpol     = ~pol;
        bus.cpha     = ~pha;
    endtask

    task automatic wait_done(input string nm);
        int c0 = done_cnt;
        int n  = 0;
        while ((done_cnt == c0) && (n < 3000)) begin
            @(posedge clk);
            n++;
        end
        chk1({nm, "_done_seen"}, done_cnt != c0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int d0, s0, n;
        bus.wrt      = 1'b0;
        bus.data_out = '0;
        bus.len      = '0;
        bus.cpol     = 1'b0;
        bus.cpha     = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        #12;
        chk1("rst_SS_n", bus.SS_n, 1'b1);
        chk1("rst_SCLK", bus.SCLK, 1'b0);
        chk1("rst_MOSI", bus.MOSI, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk("rst_data_in", 32'(bus.data_in), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Mode 0 loopback, full length
        loop = 1'b1;
        start(16'h6600, 5'd16, 1'b0, 1'b0, 1'b0);
        wait_done("m0");
        chk("m0_rises", rises, 16);
        chk("m0_falls", falls, 16);
        chk("m0_latency", lat, 67);
        chk("m0_data_in", 32'(bus.data_in), 32'h6600);
        chk1("m0_idle_sclk", bus.SCLK, 1'b0);

        // Mode 3, 8 bits against a slave returning 0x3C
        loop       = 1'b0;
        slave_word = 16'h003C;
        start(16'h00A5, 5'd8, 1'b1, 1'b1, 1'b0);
        wait_done("m3");
        chk("m3_mosi_bits", 32'(mon_bits), 32'h00A5);
        chk("m3_data_in", 32'(bus.data_in), 32'h003C);
        chk("m3_latency", lat, 35);
        chk1("m3_idle_sclk", bus.SCLK, 1'b1);
        loop = 1'b1;

        // Out-of-range lengths fall back to DATA_W
        start(16'hBEEF, 5'd0, 1'b0, 1'b0, 1'b0);
        wait_done("len0");
        chk("len0_data_in", 32'(bus.data_in), 32'hBEEF);
        chk("len0_rises", rises, 16);
        start(16'hBEEF, 5'd20, 1'b0, 1'b0, 1'b0);
        wait_done("len20");
        chk("len20_data_in", 32'(bus.data_in), 32'hBEEF);
        chk("len20_latency", lat, 67);

        // wrt while busy and wrt in the done cycle are both dropped
        d0 = done_cnt;
        s0 = ss_falls;
        start(16'h0F0F, 5'd16, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.data_out = 16'h1234;
        bus.wrt      = 1'b1;
        @(posedge clk); #1;
        bus.wrt = 1'b0;
        n = 0;
        while (!bus.done && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        chk1("ign_done_seen", bus.done, 1'b1);
        bus.wrt = 1'b1;
        @(posedge clk); #1;
        bus.wrt = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ign_done_pulses", done_cnt - d0, 1);
        chk("ign_ss_falls", ss_falls - s0, 1);
        chk("ign_data_in", 32'(bus.data_in), 32'h0F0F);
        chk1("ign_busy", bus.busy, 1'b0);

        // Async reset at SCLK edge 6 of a mode 1 transfer
        d0 = done_cnt;
        start(16'hA5C3, 5'd16, 1'b0, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("arst_SS_n", bus.SS_n, 1'b1);
        chk1("arst_SCLK", bus.SCLK, 1'b0);
        chk1("arst_busy", bus.busy, 1'b0);
        chk("arst_data_in", 32'(bus.data_in), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt - d0, 0);
        start(16'h5A3C, 5'd16, 1'b0, 1'b1, 1'b0);
        wait_done("post_rst");
        chk("post_rst_data_in", 32'(bus.data_in), 32'h5A3C);
        chk("post_rst_latency", lat, 67);

        // LSB-first request (honoured only when the option is built in)
        start(16'h0001, 5'd8, 1'b0, 1'b0, 1'b1);
        wait_done("lsb");
`ifdef SPI_LSB_FIRST_EN
        chk1("lsb_first_mosi", first_mosi, 1'b1);
`else
        chk1("lsb_first_mosi", first_mosi, 1'b0);
`endif
        chk("lsb_data_in", 32'(bus.data_in), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/spi_mstr_gen.md
Name: spi_mstr_gen

Overview:
- Parametrised successor to the fixed 8/16-bit SPI master used as a protocol-trigger stimulus source for LA_dig.
- Supports runtime transfer length from 1 to DATA_W bits and all four CPOL/CPHA modes.
- Adds a programmable SCLK divider and full-duplex MISO capture.
- Serves both as a bench stimulus source for SPI-triggering tests and as a synthesizable host-side SPI master.

Parameters:
- DATA_W, 16, maximum bits per transfer; shift-register width (minimum 2).
- HALF_DIV, 2, clk cycles per SCLK half-period (minimum 1).

Ports:
- clk  input  1  system clock (100MHz domain).
- rst_n  input  1  asynchronous active-low reset.
- wrt  input  1  start-transfer strobe; sampled only when busy=0.
- data_out  input  DATA_W  transmit word, right-justified; latched on accepted wrt.
- len  input  $clog2(DATA_W+1)  bit count; latched on accepted wrt.
- cpol  input  1  SCLK idle level; latched on accepted wrt.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accepted wrt.
- MISO  input  1  serial data from slave.
- SS_n  output  1  active-low slave select.
- SCLK  output  1  serial clock.
- MOSI  output  1  serial data to slave.
- busy  output  1  high from the cycle after wrt acceptance until done.
- done  output  1  one-clk pulse at transfer end.
- data_in  output  DATA_W  received bits, right-justified; upper bits zero; held until next accepted wrt.

Behaviour:
- Reset values: SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, data_in=0, latched cpol/cpha=0, state IDLE.
- Length rules: len=0 or len>DATA_W is treated as DATA_W. Effective length is N.
- States:
  - IDLE: accept wrt → SETUP. Latch inputs. MOSI = first bit if cpha=0.
  - SETUP: SS_n=0. After HALF_DIV clks, make the first SCLK edge → SHIFT.
  - SHIFT: toggle SCLK every HALF_DIV clks, 2N edges total. After edge 2N → HOLD.
  - HOLD: wait HALF_DIV clks, then SS_n=1, done=1, busy=0 → IDLE.
- Timing: with wrt sampled at edge T0, SS_n falls at T1. Edge k occurs at T1+k*HALF_DIV. done is asserted at T1+(2N+1)*HALF_DIV.
- SCLK idles at the latched cpol in IDLE/SETUP/HOLD. After reset it stays 0 until the first wrt latches cpol.
- cpha=0: MOSI is valid before the first edge. Odd (leading) edges sample MISO; even (trailing) edges shift the next bit onto MOSI.
- cpha=1: odd edges shift out a bit (first bit appears on edge 1); even edges sample MISO.
- Bit order is MSB first: the first bit out is data_out[N-1]. Sampled bits shift into the LSB. After N samples, data_in[N-1:0] holds the received word.
- data_in updates only at the done cycle, never mid-transfer.
- wrt while busy=1 is ignored, with no queueing. wrt in the same cycle as done is also ignored; busy=0 takes effect the next cycle.
- An asynchronous reset mid-transfer forces all reset values immediately. No done pulse is produced.
- A change to cpol/cpha/len/data_out during a transfer has no effect.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: adds input port lsb_first (1 bit), latched on wrt.
  - When 1, the first bit out is data_out[0] and the shift goes right.
  - Received bits fill from bit N-1 down to bit 0, so data_in[0] holds the first bit received.
- Undefined: port absent; MSB-first only.

Test Plan:
- Mode 0 loopback: DATA_W=16, HALF_DIV=2, len=16, data_out=16'h6600, MISO tied to MOSI.
  - Required: 16 rising and 16 falling SCLK edges; SCLK low at idle.
  - Required: done 67 clk after the wrt edge; data_in=16'h6600.
- Mode 3, len=8, data_out=16'h00A5, slave model returns 8'h3C:
  - Required: SCLK idles high; MOSI bits 1010_0101 sampled on rising edges.
  - Required: data_in=16'h003C; done 35 clk after wrt.
- len=0 and len=20 with data_out=16'hBEEF, loopback: both transfer 16 bits; data_in=16'hBEEF.
- wrt pulsed at cycle 5 of a busy transfer with data_out=16'h1234:
  - Required: the original transfer completes unchanged with a single done pulse.
  - Required: no second SS_n assertion.
- rst_n low at edge 6 of a mode 1 transfer:
  - Required: SS_n=1, SCLK=0, busy=0, data_in=0 immediately; no done pulse.
  - Required: the next wrt runs normally.
- Define SPI_LSB_FIRST_EN, lsb_first=1, len=8, data_out=16'h0001, loopback:
  - Required: first MOSI bit=1, data_in=16'h0001.
  - Required: without the macro, the same stimulus gives first MOSI bit=0.
